// File: rtl/ysyx_2022040010_uncache_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ysyx_2022040010_uncache_ctrl_pkg                              |
// | Purpose  : Shared state encoding and bus-response helpers for the        |
// |            uncached (MMIO) access sequencer.                             |
// | Contents : uc_state_e (3-bit FSM encoding), AXI_RESP_OKAY,               |
// |            resp_is_err() helper.                                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package ysyx_2022040010_uncache_ctrl_pkg;

  typedef enum logic [2:0] {
    UC_IDLE = 3'd0,
    UC_RA   = 3'd1,
    UC_RD   = 3'd2,
    UC_WA   = 3'd3,
    UC_WB   = 3'd4,
    UC_DONE = 3'd5
  } uc_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Anything other than OKAY (SLVERR, DECERR, EXOKAY on a non-exclusive
  // access) is reported to the LSU as a failed access.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_2022040010_uncache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ysyx_2022040010_uncache_ctrl                                  |
// | Purpose  : Sequences single-beat uncached loads/stores from the LSU onto |
// |            an AXI4-lite style port, stalls the pipeline meanwhile, and   |
// |            drives the load-data capture register. A watchdog turns a     |
// |            silent device into an error response.                         |
// | Ports    : clk, rst (sync, active-high)                                  |
// |            req_*_i      LSU request (valid/uncache/wen/addr/wdata/wstrb) |
// |            stall_o, resp_valid_o, resp_err_o  pipeline handshake         |
// |            refresh_o, hit_o, uncache_o        data capture register ctl  |
// |            ar_*, r_*, aw_*, w_*, b_*          bus channels               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ysyx_2022040010_uncache_ctrl
  import ysyx_2022040010_uncache_ctrl_pkg::*;
#(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  input  logic            req_uncache_i,
  input  logic            req_wen_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  input  logic [DW/8-1:0] req_wstrb_i,
  output logic            stall_o,
  output logic            resp_valid_o,
  output logic            resp_err_o,
  output logic            refresh_o,
  output logic            hit_o,
  output logic            uncache_o,
  output logic            ar_valid_o,
  input  logic            ar_ready_i,
  output logic [AW-1:0]   ar_addr_o,
  input  logic            r_valid_i,
  output logic            r_ready_o,
  input  logic [1:0]      r_resp_i,
  output logic            aw_valid_o,
  input  logic            aw_ready_i,
  output logic [AW-1:0]   aw_addr_o,
  output logic            w_valid_o,
  input  logic            w_ready_i,
  output logic [DW-1:0]   w_data_o,
  output logic [DW/8-1:0] w_strb_o,
  input  logic            b_valid_i,
  output logic            b_ready_o,
  input  logic [1:0]      b_resp_i
);

  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_limit = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  uc_state_e           state_q, state_d;
  logic                err_q, err_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW/8-1:0]     wstrb_q, wstrb_d;

  logic w_timeout;
  logic w_aw_ok;
  logic w_w_ok;

  assign w_timeout = (TIMEOUT != 0) && (cnt_q == c_cnt_limit);
  assign w_aw_ok   = aw_done_q | aw_ready_i;
  assign w_w_ok    = w_done_q  | w_ready_i;

  assign ar_addr_o = addr_q;
  assign aw_addr_o = addr_q;
  assign w_data_o  = wdata_q;
  assign w_strb_o  = wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UC_IDLE;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    // Saturating count; only meaningful in RD/WB where it is cleared on entry.
    cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + c_cnt_one;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    stall_o      = 1'b0;
    resp_valid_o = 1'b0;
    resp_err_o   = 1'b0;
    refresh_o    = 1'b0;
    hit_o        = 1'b0;
    ar_valid_o   = 1'b0;
    r_ready_o    = 1'b0;
    aw_valid_o   = 1'b0;
    w_valid_o    = 1'b0;
    b_ready_o    = 1'b0;

    unique case (state_q)
      UC_IDLE: begin
        // Keep draining so a response that arrives after a timeout is
        // swallowed instead of wedging the slave.
        r_ready_o = 1'b1;
        b_ready_o = 1'b1;
        if (req_valid_i && req_uncache_i) begin
          stall_o   = 1'b1;
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          wstrb_d   = req_wstrb_i;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_wen_i ? UC_WA : UC_RA;
        end
      end
      UC_RA: begin
        stall_o    = 1'b1;
        ar_valid_o = 1'b1;
        if (ar_ready_i) begin
          cnt_d   = '0;
          state_d = UC_RD;
        end
      end
      UC_RD: begin
        stall_o   = 1'b1;
        r_ready_o = 1'b1;
        if (r_valid_i) begin
          refresh_o = 1'b1;
          hit_o     = 1'b1;
          err_d     = resp_is_err(r_resp_i);
          state_d   = UC_DONE;
        end else if (w_timeout) begin
          err_d   = 1'b1;
          state_d = UC_DONE;
        end
      end
      UC_WA: begin
        // AW and W are independent; each valid drops after its own handshake.
        stall_o    = 1'b1;
        aw_valid_o = !aw_done_q;
        w_valid_o  = !w_done_q;
        aw_done_d  = w_aw_ok;
        w_done_d   = w_w_ok;
        if (w_aw_ok && w_w_ok) begin
          cnt_d   = '0;
          state_d = UC_WB;
        end
      end
      UC_WB: begin
        stall_o   = 1'b1;
        b_ready_o = 1'b1;
        if (b_valid_i) begin
          err_d   = resp_is_err(b_resp_i);
          state_d = UC_DONE;
        end else if (w_timeout) begin
          err_d   = 1'b1;
          state_d = UC_DONE;
        end
      end
      UC_DONE: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        state_d      = UC_IDLE;
      end
      default: begin
        state_d = UC_IDLE;
      end
    endcase

    // Reset silences the bus immediately, independent of the current state.
    if (rst) begin
      stall_o      = 1'b0;
      resp_valid_o = 1'b0;
      resp_err_o   = 1'b0;
      refresh_o    = 1'b0;
      hit_o        = 1'b0;
      ar_valid_o   = 1'b0;
      r_ready_o    = 1'b0;
      aw_valid_o   = 1'b0;
      w_valid_o    = 1'b0;
      b_ready_o    = 1'b0;
    end
  end

  assign uncache_o = (state_q != UC_IDLE) && !rst;

endmodule
`default_nettype wire
